// File: rtl/cmp_pkg.sv
// Shared definitions for the nibble-serial magnitude compare controller.
package cmp_pkg;

    // Controller states (plain constants for legacy tool compatibility)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_FIN    = 2'd3;

    // Comparator flag vector {gt, lt, eq}; only these three values are legal
    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_LT = 3'b010;
    localparam logic [2:0] FLAG_EQ = 3'b001;

    // Number of nibbles in an operand word
    function automatic int unsigned nib_count(input int unsigned word_w);
        return word_w / 4;
    endfunction

    // Width of the nibble index, never less than one bit
    function automatic int unsigned idx_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

    // True when the comparator flags carry exactly one legal code
    function automatic logic flags_onehot(input logic [2:0] f);
        return (f == FLAG_GT) || (f == FLAG_LT) || (f == FLAG_EQ);
    endfunction

endpackage

// File: rtl/nibble_select.sv
// Combinational mux returning nibble i_idx of a captured operand word.
module nibble_select #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [WORD_W-1:0] i_word,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [3:0]        o_nib
);

    // Nibble idx occupies bits [4*idx+3 : 4*idx]
    always_comb begin
        o_nib = i_word[{i_idx, 2'b00} +: 4];
    end

endmodule

// File: rtl/nibble_serial_compare_ctrl.sv
// Walks two operands MSB nibble first through an external 4-bit comparator,
// stopping at the first unequal nibble, and reports a registered word result.
module nibble_serial_compare_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] b_word,
    output logic [3:0]        cmp_a,
    output logic [3:0]        cmp_b,
    input  logic              cmp_gt,
    input  logic              cmp_lt,
    input  logic              cmp_eq,
    output logic              busy,
    output logic              done,
    output logic              gt,
    output logic              lt,
    output logic              eq,
    output logic              err
);

    localparam int unsigned NIB   = nib_count(WORD_W);
    localparam int unsigned IDX_W = idx_width(NIB);
    localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NIB - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    // With no settle time a freshly driven nibble is sampled on the next edge
    localparam state_t LOAD_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic              r_busy;
    logic              r_done;
    logic              r_gt;
    logic              r_lt;
    logic              r_eq;
    logic              r_err;

    logic [2:0]        w_flags;
    logic              w_onehot;
    logic [3:0]        w_nib_a;
    logic [3:0]        w_nib_b;

    assign w_flags  = {cmp_gt, cmp_lt, cmp_eq};
    assign w_onehot = flags_onehot(w_flags);

    nibble_select #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_sel_a (
        .i_word (r_a),
        .i_idx  (r_idx),
        .o_nib  (w_nib_a)
    );

    nibble_select #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_sel_b (
        .i_word (r_b),
        .i_idx  (r_idx),
        .o_nib  (w_nib_b)
    );

    // Controller FSM, operand capture and registered result
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // FIN behaves like IDLE so a start in the done cycle is taken
                ST_IDLE, ST_FIN: begin
                    r_state <= ST_IDLE;
                    if (start) begin
                        r_a     <= a_word;
                        r_b     <= b_word;
                        r_idx   <= IDX_TOP;
                        r_cnt   <= CNT_LOAD;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD_STATE;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (!w_onehot || cmp_gt || cmp_lt || (r_idx == '0)) begin
                        r_err   <= !w_onehot;
                        r_gt    <= w_onehot && cmp_gt;
                        r_lt    <= w_onehot && cmp_lt;
                        r_eq    <= w_onehot && cmp_eq;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_cnt   <= CNT_LOAD;
                        r_state <= LOAD_STATE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmp_a = w_nib_a;
    assign cmp_b = w_nib_b;
    assign busy  = r_busy;
    assign done  = r_done;
    assign gt    = r_gt;
    assign lt    = r_lt;
    assign eq    = r_eq;
    assign err   = r_err;

endmodule
